muldiv_unit: RTL

Iterative RV32M multiply/divide execution unit; sits downstream of the core's decode/register-read, consuming rs1/rs2 operands and funct3 for OP instructions with funct7=0000001. Produces a 32-bit result for write-back with a start/busy/done handshake; the core stalls its PC while busy. Radix-2, one bit per cycle, with a single-cycle fast path for the architecturally defined divide corner cases.

---
 rtl/rv32m_pkg.sv | 39 +++
 rtl/muldiv_signfix.sv | 57 +++++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 opcodes,
// sequencer states, default width and small opcode-decoding helpers.
package rv32m_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // All divide/remainder opcodes have funct3[2] set.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned iterative core: converts incoming
// operands to magnitude + sign, and turns the finished accumulator into the
// architectural result (negation and word/quotient/remainder selection).
module muldiv_signfix
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]        in_op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   a_mag,
    output logic [XLEN-1:0]   b_mag,
    output logic              a_neg,
    output logic              b_neg,
    input  logic [2:0]        out_op,
    input  logic              out_a_neg,
    input  logic              out_b_neg,
    input  logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   fixed
);

    localparam logic [XLEN-1:0]   ONE_W = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_D = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // Operand conditioning; the magnitude of the most negative value is
    // the same bit pattern read as unsigned, which the core handles fine.
    always_comb begin
        a_neg = a[XLEN-1] & a_is_signed(in_op);
        b_neg = b[XLEN-1] & b_is_signed(in_op);
        a_mag = a_neg ? (~a + ONE_W) : a;
        b_mag = b_neg ? (~b + ONE_W) : b;
    end

    // Result fix-up: product/quotient negate on differing signs, remainder
    // follows the dividend's sign; unsigned ops carry both sign flags as 0.
    always_comb begin
        prod  = (out_a_neg ^ out_b_neg) ? (~acc + ONE_D) : acc;
        quo   = acc[XLEN-1:0];
        rem   = acc[2*XLEN-1:XLEN];
        fixed = '0;
        case (out_op)
            F3_MUL:                        fixed = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fixed = prod[2*XLEN-1:XLEN];
            F3_DIV:                        fixed = (out_a_neg ^ out_b_neg) ? (~quo + ONE_W) : quo;
            F3_DIVU:                       fixed = quo;
            F3_REM:                        fixed = out_a_neg ? (~rem + ONE_W) : rem;
            F3_REMU:                       fixed = rem;
            default:                       fixed = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit. One accumulator serves both
// operations: for multiply the high half accumulates partial products while
// the low half shifts out multiplier bits; for divide the high half is the
// partial remainder and the low half shifts dividend bits out / quotient in.
module muldiv_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state, state_next;
    logic [2:0]        op_reg;
    logic              sign_a_reg, sign_b_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic [CW-1:0]     cnt_reg;
    logic [XLEN-1:0]   result_reg;
    logic              done_reg;

    logic              load, fast, step, fix;
    logic [XLEN-1:0]   a_mag, b_mag, fix_value, fast_value;
    logic              a_neg, b_neg;
    logic              div_by_zero, overflow, fast_hit;
    logic [2*XLEN-1:0] acc_step;

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .in_op     (funct3),
        .a         (a),
        .b         (b),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .out_op    (op_reg),
        .out_a_neg (sign_a_reg),
        .out_b_neg (sign_b_reg),
        .acc       (acc_reg),
        .fixed     (fix_value)
    );

    // Architecturally defined divide corner cases resolved without iterating.
    always_comb begin
        div_by_zero = (b == '0);
        overflow    = (a == MOST_NEG) && (b == '1) && !funct3[0];
        fast_hit    = is_div(funct3) && (div_by_zero || overflow);
        if (div_by_zero)
            fast_value = funct3[1] ? a : '1;
        else
            fast_value = funct3[1] ? '0 : MOST_NEG;
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        logic [XLEN-1:0] hi, lo, trial;
        logic [XLEN:0]   add_sum, shifted;
        logic            no_borrow;
        hi        = acc_reg[2*XLEN-1:XLEN];
        lo        = acc_reg[XLEN-1:0];
        add_sum   = {1'b0, hi} + {1'b0, opnd_reg};
        shifted   = {hi, lo[XLEN-1]};
        no_borrow = (shifted >= {1'b0, opnd_reg});
        trial     = shifted[XLEN-1:0] - opnd_reg;
        if (is_div(op_reg))
            acc_step = {(no_borrow ? trial : shifted[XLEN-1:0]), lo[XLEN-2:0], no_borrow};
        else if (lo[0])
            acc_step = {add_sum, lo[XLEN-1:1]};
        else
            acc_step = {1'b0, hi, lo[XLEN-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        fast       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (fast_hit) begin
                        fast = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (cnt_reg == '0) state_next = ST_FIX;
            end
            ST_FIX: begin
                fix        = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: operand capture, iteration, result and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                op_reg     <= funct3;
                sign_a_reg <= a_neg;
                sign_b_reg <= b_neg;
                acc_reg    <= {{XLEN{1'b0}}, (is_div(funct3) ? a_mag : b_mag)};
                opnd_reg   <= is_div(funct3) ? b_mag : a_mag;
                cnt_reg    <= CW'(XLEN - 1);
            end
            if (step) begin
                acc_reg <= acc_step;
                cnt_reg <= cnt_reg - {{(CW-1){1'b0}}, 1'b1};
            end
            if (fast) begin
                result_reg <= fast_value;
                done_reg   <= 1'b1;
            end
            if (fix) begin
                result_reg <= fix_value;
                done_reg   <= 1'b1;
            end
        end
    end

    assign busy   = (state != ST_IDLE);
    assign done   = done_reg;
    assign result = result_reg;

endmodule
